// File: rtl/arm_pkg.sv
// arm_pkg: shared condition encodings and flag bit positions for the ARM datapath
package arm_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder/ALU-side signals of the condition-code unit
interface cond_logic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_check.sv
// cond_check: evaluates a 4-bit condition field against stored NZCV flags
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);
    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = n ~^ v;

    // decode the condition; AL and the 1111 encoding both always pass
    always_comb begin
        CondEx = 1'b1;
        case (cond_e'(Cond))
            EQ:      CondEx = z;
            NE:      CondEx = ~z;
            CS:      CondEx = c;
            CC:      CondEx = ~c;
            MI:      CondEx = n;
            PL:      CondEx = ~n;
            VS:      CondEx = v;
            VC:      CondEx = ~v;
            HI:      CondEx = c & ~z;
            LS:      CondEx = ~c | z;
            GE:      CondEx = ge;
            LT:      CondEx = ~ge;
            GT:      CondEx = ~z & ge;
            LE:      CondEx = z | ~ge;
            default: CondEx = 1'b1;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register plus condition gating of PC/register/memory writes
module cond_logic
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    cond_logic_if.slave bus
);
    logic [1:0] nz;
    logic [1:0] cv;
    logic       cond_ex;

    cond_check u_cond_check (
        .Cond   (bus.Cond),
        .Flags  (bus.Flags),
        .CondEx (cond_ex)
    );

    // N,Z half: cleared by reset, otherwise loaded only by a passing flag-setting instruction
    always_ff @(posedge clk) begin
        if (!reset)
            nz <= 2'b00;
        else if (bus.FlagW[FLAGW_NZ] && cond_ex)
            nz <= bus.ALUFlags[FLAG_N:FLAG_Z];
    end

    // C,V half: separate enable so logical ops can preserve carry and overflow
    always_ff @(posedge clk) begin
        if (!reset)
            cv <= 2'b00;
        else if (bus.FlagW[FLAGW_CV] && cond_ex)
            cv <= bus.ALUFlags[FLAG_C:FLAG_V];
    end

    assign bus.Flags    = {nz, cv};
    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = reset & bus.PCS & cond_ex;
    assign bus.RegWrite = reset & bus.RegW & ~bus.NoWrite & cond_ex;
    assign bus.MemWrite = reset & bus.MemW & cond_ex;
endmodule

// File: doc/cond_logic.md
# cond_logic

Condition-code unit for the single-cycle ARM datapath, the consumer of the ALU's N/Z/C/V outputs. It holds the architectural NZCV flag register and updates it from the ALU flags under decoder control. It evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's PC-source, register-write and memory-write requests so that a failed condition turns the instruction into a no-op.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low (asserted when 0, sampled on `clk` rising edge).
- `Cond` input 4: instruction bits [31:28].
- `ALUFlags` input 4: {N,Z,C,V} from the ALU in the current cycle.
- `FlagW` input 2: [1] = update N,Z; [0] = update C,V.
- `PCS` input 1: decoder requests PC write (branch or Rd==PC).
- `RegW` input 1: decoder requests register-file write.
- `MemW` input 1: decoder requests data-memory write.
- `NoWrite` input 1: compare-class instruction; suppresses the register write.
- `PCSrc` output 1: PCS & CondEx, forced 0 in reset.
- `RegWrite` output 1: RegW & ~NoWrite & CondEx, forced 0 in reset.
- `MemWrite` output 1: MemW & CondEx, forced 0 in reset.
- `CondEx` output 1: condition passed for the current instruction.
- `Flags` output 4: stored {N,Z,C,V}; reset value 4'b0000.

## Operation
- Flag register is 4 bits, bit order {N,Z,C,V}, the same as `ALUFlags`.
- `CondEx` is combinational from `Cond` and the stored `Flags` only. It never uses `ALUFlags`.
- Condition decode:
  - EQ 0000 → Z
  - NE 0001 → ~Z
  - CS 0010 → C
  - CC 0011 → ~C
  - MI 0100 → N
  - PL 0101 → ~N
  - VS 0110 → V
  - VC 0111 → ~V
  - HI 1000 → C&~Z
  - LS 1001 → ~C|Z
  - GE 1010 → N~^V
  - LT 1011 → N^V
  - GT 1100 → ~Z&(N~^V)
  - LE 1101 → Z|(N^V)
  - AL 1110 → 1
  - 1111 → 1 (treated as AL)
- Flag update at each rising edge:
  - If `reset`==0: Flags ← 0000.
  - Else Flags[3:2] ← ALUFlags[3:2] when FlagW[1]&CondEx.
  - Else Flags[1:0] ← ALUFlags[1:0] when FlagW[0]&CondEx.
  - Unselected halves hold their value.
- Logical ops (AND/ORR) are decoded with FlagW=10, so C,V are preserved even though the ALU drives C=V=0 for them.
- A failed condition blocks every side effect: no flag update, PCSrc=0, RegWrite=0, MemWrite=0.
- While `reset`==0, the three gated outputs are 0 regardless of the inputs. `CondEx` and `Flags` stay observable.

## Timing
- Gating outputs (`PCSrc`, `RegWrite`, `MemWrite`, `CondEx`) have zero latency.
- Flag update latency is one cycle. An S-suffixed instruction in cycle n changes `Flags` at the edge ending cycle n. The instruction in cycle n+1 evaluates its condition against the new flags.
- The setting instruction's own condition uses the flags from before that edge. A conditional S instruction (e.g. ADDEQS) needs Z=1 from prior state to update.
- Reset dominates: `reset`==0 together with FlagW=11 and CondEx=1 still yields Flags=0000 after the edge.
- Reset deasserting mid-program: the first cycle with `reset`==1 evaluates conditions against Flags=0000. In that cycle EQ fails and NE passes.
- Inputs are assumed stable before the edge (single-cycle datapath). The block contains no other state and no multi-cycle handshakes.

## Structure
- Shared package `arm_pkg`:
  - enum `cond_e` with the 16 condition encodings.
  - localparams `FLAG_N=3`, `FLAG_Z=2`, `FLAG_C=1`, `FLAG_V=0`.
  - localparams `FLAGW_NZ=1`, `FLAGW_CV=0`.
- One sub-module, `cond_check`: pure combinational (`Cond`, `Flags`) → `CondEx`. It is reusable by a later pipelined core.
- The flag registers and output gating live in `cond_logic`. Each 2-bit half uses its own enabled flop.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with FlagW=11, ALUFlags=1111, PCS=RegW=MemW=1, Cond=1110. Required: Flags=0000 and all gated outputs 0. After release: Cond=0000 → CondEx=0; Cond=0001 → CondEx=1.
- Split update: Cond=AL, FlagW=10, ALUFlags=0100 → next cycle Flags=0100. Then FlagW=01, ALUFlags=1011 → Flags=0111.
- Condition sweep: for stored Flags ∈ {0000, 0100, 0010, 1001, 1000, 0011}, sweep all 16 `Cond` values. Check `CondEx` against the decode list. Example: Flags=1001 with GE gives 1, LT gives 0, GT gives 1.
- Failed condition: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1111, PCS=RegW=MemW=1. Required: PCSrc=RegWrite=MemWrite=0, and Flags still 0000 next cycle.
- Compare: Cond=AL, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 (CMP equal). Required: RegWrite=0 in that cycle and Flags=0110 next cycle. A following Cond=0000 branch with PCS=1 gives PCSrc=1.
- Reset mid-operation: Flags=1111, then `reset`=0 for one cycle with FlagW=11 and ALUFlags=1010. Required: Flags=0000, not 1010.
